// File: rtl/dmem_access_unit.sv
// MEM-stage data memory access unit: qualifies load/store controls, drives a
// req/ack handshake, stalls the pipeline, and returns extended load data.
module dmem_access_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memwrite,
  input  logic            memtoreg,
  input  logic [1:0]      swhb,
  input  logic [1:0]      lwhb,
  input  logic            lunsigned,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            rvalid,
  output logic            misalign,
  output logic            timeout,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] size_q;
  logic [1:0] off_q;
  logic       load_q;
  logic       uns_q;

  logic            store_ok;
  logic            load_ok;
  logic            acc_ok;
  logic [1:0]      acc_size;
  logic [1:0]      off;
  logic            misaligned;
  logic            start;
  logic [3:0]      be_next;
  logic [XLEN-1:0] wdata_next;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_ext;

  // A store and a load in the same instruction cannot both be honoured; the store wins.
  assign store_ok   = memwrite && (swhb != 2'b00);
  assign load_ok    = memtoreg && (lwhb != 2'b00);
  assign acc_ok     = store_ok || load_ok;
  assign acc_size   = store_ok ? swhb : lwhb;
  assign off        = addr[1:0];
  assign misaligned = ((acc_size == 2'b11) && (off != 2'b00)) ||
                      ((acc_size == 2'b10) && off[0]);
  assign start      = (state == IDLE) && acc_ok && !misaligned;

  // NOTE: stall is combinational so the pipeline freezes in the very cycle the
  // access is seen; it is gated by reset so a flush never holds the pipe.
  assign stall = !reset && ((state == WAIT) || start);

  // NOTE: every variable assigned in an always_comb gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (acc_size)
      2'b01: begin
        be_next    = 4'b0001 << off;
        wdata_next = {(XLEN/8){wdata[7:0]}};
      end
      2'b10: begin
        be_next    = 4'b0011 << {off[1], 1'b0};
        wdata_next = {(XLEN/16){wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign half_sel = 16'(mem_rdata >> {off_q, 3'b000});

  always_comb begin
    load_ext = mem_rdata;
    case (size_q)
      2'b01:   load_ext = {{(XLEN-8){half_sel[7] & ~uns_q}}, half_sel[7:0]};
      2'b10:   load_ext = {{(XLEN-16){half_sel[15] & ~uns_q}}, half_sel};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and later assignments override earlier
  // defaults within the same block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      size_q    <= '0;
      off_q     <= '0;
      load_q    <= 1'b0;
      uns_q     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      misalign  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      rvalid   <= 1'b0;
      misalign <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_ok && misaligned) begin
            misalign <= 1'b1;
            rdata    <= '0;
          end else if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= store_ok;
            mem_addr  <= {addr[XLEN-1:2], 2'b00};
            mem_be    <= be_next;
            mem_wdata <= wdata_next;
            size_q    <= acc_size;
            off_q     <= off;
            load_q    <= !store_ok;
            uns_q     <= lunsigned;
            cnt       <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            rvalid  <= load_q;
            if (load_q) rdata <= load_ext;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            rdata   <= '0;
            timeout <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: a transaction-level model checked
// every cycle, plus directed accesses with hand-computed literal expectations.
module tb_dmem_access_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite, memtoreg, lunsigned;
  logic [1:0]  swhb, lwhb;
  logic [31:0] addr, wdata;
  logic        stall, rvalid, misalign, timeout, mem_req, mem_we, mem_ack;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_access_unit #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memtoreg(memtoreg),
    .swhb(swhb), .lwhb(lwhb), .lunsigned(lunsigned), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rvalid(rvalid), .misalign(misalign),
    .timeout(timeout), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [3:0] be_f(input int n, input int o);
    logic [3:0] be;
    int base;
    base = o - (o % n);
    for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + n);
    return be;
  endfunction

  function automatic logic [31:0] wd_f(input logic [31:0] d, input int n);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ext_f(input logic [31:0] w, input int n, input int o, input bit uns);
    logic [31:0] r;
    logic [31:0] ones;
    if (n == 4) return w;
    r = '0;
    ones = '1;
    for (int k = 0; k < n; k++) r[8*k +: 8] = w[8*(o + k) +: 8];
    if (!uns && r[8*n - 1]) r = r | (ones << (8*n));
    return r;
  endfunction

  function automatic void decode(output bit ok, output bit mis, output bit st, output int n);
    bit ld;
    logic [1:0] code;
    st   = memwrite && (swhb != 2'b00);
    ld   = memtoreg && (lwhb != 2'b00);
    ok   = st || ld;
    code = st ? swhb : lwhb;
    n    = (code == 2'b11) ? 4 : (code == 2'b10) ? 2 : 1;
    mis  = ok && (((n == 4) && (addr[1:0] != 2'b00)) || ((n == 2) && addr[0]));
  endfunction

  bit          m_live = 0, m_busy = 0, m_done = 0, m_load = 0, m_uns = 0, m_we = 0;
  bit          m_rvalid = 0, m_mis = 0, m_to = 0;
  int          m_wait = 0, m_n = 1, m_off = 0;
  logic [31:0] m_addr = '0, m_wd = '0, m_rdata = '0;
  logic [3:0]  m_be = '0;

  always @(posedge clk) begin
    bit ok, mis, st;
    int n;
    if (reset) begin
      m_live = 1; m_busy = 0; m_done = 0;
      m_rvalid = 0; m_mis = 0; m_to = 0; m_rdata = '0;
    end else if (m_live) begin
      m_rvalid = 0; m_mis = 0; m_to = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_busy) begin
        m_wait++;
        if (mem_ack) begin
          m_busy = 0; m_done = 1;
          if (m_load) begin
            m_rvalid = 1;
            m_rdata  = ext_f(mem_rdata, m_n, m_off, m_uns);
          end
        end else if (m_wait == TIMEOUT) begin
          m_busy = 0; m_done = 1; m_to = 1; m_rdata = '0;
        end
      end else begin
        decode(ok, mis, st, n);
        if (ok && mis) begin
          m_mis = 1; m_rdata = '0;
        end else if (ok) begin
          m_busy = 1; m_wait = 0; m_load = !st; m_we = st;
          m_n = n; m_off = int'(addr[1:0]); m_uns = lunsigned;
          m_addr = {addr[31:2], 2'b00};
          m_be   = be_f(n, m_off);
          m_wd   = wd_f(wdata, n);
        end
      end
    end
  end

  always @(negedge clk) begin
    bit ok, mis, st;
    int n;
    if (m_live) begin
      decode(ok, mis, st, n);
      check("stall", stall, !reset && (m_busy || (!m_done && ok && !mis)));
      check("mem_req", mem_req, m_busy);
      if (m_busy) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_be", mem_be, m_be);
        check("mem_we", mem_we, m_we);
        if (m_we) check("mem_wdata", mem_wdata, m_wd);
      end
      check("rvalid", rvalid, m_rvalid);
      check("misalign", misalign, m_mis);
      check("timeout", timeout, m_to);
      if (m_rvalid || m_mis || m_to) check("rdata", rdata, m_rdata);
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct packed {
    int          stall_cyc;
    int          req_cyc;
    int          rv_cyc;
    int          mis_cyc;
    int          to_cyc;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        we;
  } result_t;

  task automatic sample(inout result_t r);
    if (stall) r.stall_cyc++;
    if (rvalid) begin r.rv_cyc++; r.rdata = rdata; end
    if (misalign) begin r.mis_cyc++; r.rdata = rdata; end
    if (timeout) begin r.to_cyc++; r.rdata = rdata; end
  endtask

  task automatic clear_inputs();
    memwrite = 0; memtoreg = 0; swhb = 2'b00; lwhb = 2'b00;
    lunsigned = 0; addr = '0; wdata = '0; mem_ack = 0;
  endtask

  // ack_at: WAIT cycle (1-based) in which mem_ack is raised; 0 = never.
  task automatic access(input bit st, input bit both, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input bit uns,
                        input int ack_at, input logic [31:0] rd, output result_t r);
    bit done;
    r = '0;
    memwrite  = st;
    memtoreg  = !st || both;
    swhb      = st ? sz : 2'b00;
    lwhb      = (!st || both) ? sz : 2'b00;
    addr      = a;
    wdata     = wd;
    lunsigned = uns;
    done      = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      sample(r);
      if (mem_req) begin
        r.req_cyc++;
        r.addr = mem_addr; r.be = mem_be; r.wd = mem_wdata; r.we = mem_we;
        mem_ack   = (r.req_cyc == ack_at);
        mem_rdata = rd;
      end
      if (!stall) done = 1;
      @(posedge clk); #1;
      mem_ack = 0;
    end
    check("access_completes", done, 1);
    clear_inputs();
    @(negedge clk);
    sample(r);
    @(posedge clk); #1;
  endtask

  result_t r;

  initial begin
    reset = 1;
    mem_rdata = '0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_flags", {rvalid, misalign, timeout, mem_we}, 0);
    @(posedge clk); #1;
    reset = 0;

    // sw with ack in the 3rd WAIT cycle
    access(1, 0, 2'b11, 32'h104, 32'hDEADBEEF, 0, 3, 32'h0, r);
    check("sw_stall_cycles", r.stall_cyc, 4);
    check("sw_req_cycles", r.req_cyc, 3);
    check("sw_addr", r.addr, 32'h104);
    check("sw_be", r.be, 4'b1111);
    check("sw_we", r.we, 1);
    check("sw_wdata", r.wd, 32'hDEADBEEF);
    check("sw_rvalid", r.rv_cyc, 0);

    // sb / sh lane replication
    access(1, 0, 2'b01, 32'h203, 32'h000000A5, 0, 1, 32'h0, r);
    check("sb_be", r.be, 4'b1000);
    check("sb_wdata", r.wd, 32'hA5A5A5A5);
    check("sb_latency_stall", r.stall_cyc, 2);
    access(1, 0, 2'b10, 32'h202, 32'h00001234, 0, 2, 32'h0, r);
    check("sh_be", r.be, 4'b1100);
    check("sh_wdata", r.wd, 32'h12341234);

    // store wins when both are requested
    access(1, 1, 2'b01, 32'h301, 32'h0000005A, 0, 1, 32'hFFFFFFFF, r);
    check("both_we", r.we, 1);
    check("both_be", r.be, 4'b0010);
    check("both_rvalid", r.rv_cyc, 0);

    // load extraction, immediate ack
    access(0, 0, 2'b01, 32'h103, 32'h0, 0, 1, 32'h80FF7F01, r);
    check("lb_rdata", r.rdata, 32'hFFFFFF80);
    check("lb_rvalid_cycles", r.rv_cyc, 1);
    check("lb_stall_cycles", r.stall_cyc, 2);
    access(0, 0, 2'b01, 32'h103, 32'h0, 1, 1, 32'h80FF7F01, r);
    check("lbu_rdata", r.rdata, 32'h00000080);
    access(0, 0, 2'b10, 32'h102, 32'h0, 0, 1, 32'h80FF7F01, r);
    check("lh_rdata", r.rdata, 32'hFFFF80FF);
    check("lh_be", r.be, 4'b1100);
    access(0, 0, 2'b10, 32'h100, 32'h0, 1, 1, 32'h80FF7F01, r);
    check("lhu_rdata", r.rdata, 32'h00007F01);
    access(0, 0, 2'b11, 32'h100, 32'h0, 0, 1, 32'h80FF7F01, r);
    check("lw_rdata", r.rdata, 32'h80FF7F01);
    check("lw_rvalid_cycles", r.rv_cyc, 1);

    // misaligned accesses
    access(0, 0, 2'b11, 32'h102, 32'h0, 0, 1, 32'h0, r);
    check("lw_mis_req", r.req_cyc, 0);
    check("lw_mis_stall", r.stall_cyc, 0);
    check("lw_mis_pulses", r.mis_cyc, 1);
    check("lw_mis_rdata", r.rdata, 0);
    check("lw_mis_rvalid", r.rv_cyc, 0);
    access(1, 0, 2'b10, 32'h101, 32'h1234, 0, 1, 32'h0, r);
    check("sh_mis_req", r.req_cyc, 0);
    check("sh_mis_pulses", r.mis_cyc, 1);

    // ack on the last permitted WAIT cycle, then a true timeout
    access(0, 0, 2'b11, 32'h100, 32'h0, 0, TIMEOUT, 32'h12345678, r);
    check("late_ack_rdata", r.rdata, 32'h12345678);
    check("late_ack_timeout", r.to_cyc, 0);
    check("late_ack_req", r.req_cyc, TIMEOUT);
    access(0, 0, 2'b11, 32'h100, 32'h0, 0, 0, 32'h0, r);
    check("to_req_cycles", r.req_cyc, TIMEOUT);
    check("to_stall_cycles", r.stall_cyc, TIMEOUT + 1);
    check("to_pulses", r.to_cyc, 1);
    check("to_rdata", r.rdata, 0);
    check("to_rvalid", r.rv_cyc, 0);

    // reset in the 2nd WAIT cycle, late ack ignored
    memtoreg = 1; lwhb = 2'b11; addr = 32'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1; memtoreg = 0; lwhb = 2'b00;
    @(posedge clk); #1;
    reset = 0; mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rst_wait_req", mem_req, 0);
    check("rst_wait_stall", stall, 0);
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    check("rst_wait_rvalid", rvalid, 0);
    check("rst_wait_rdata", rdata, 0);
    @(posedge clk); #1;

    // back-to-back stores after reset
    access(1, 0, 2'b11, 32'h10, 32'h01020304, 0, 1, 32'h0, r);
    check("b2b_sw_be", r.be, 4'b1111);
    check("b2b_sw_stall", r.stall_cyc, 2);
    access(1, 0, 2'b01, 32'h11, 32'h000000C3, 0, 2, 32'h0, r);
    check("b2b_sb_be", r.be, 4'b0010);
    check("b2b_sb_wdata", r.wd, 32'hC3C3C3C3);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
